// File: rtl/adc_link_pkg.sv
// Shared definitions for the ADC sample link (sender and receiver):
// word width, bank depth, sample_mode codes, write-FSM encodings and
// the mode-to-frame-length mapping.
package adc_link_pkg;

  localparam int ADC_DATA_W    = 16;
  localparam int ADC_MAX_DEPTH = 64;
  localparam int ADC_ADDR_W    = 6;
  localparam int ADC_LEN_W     = ADC_ADDR_W + 1;

  localparam logic [3:0] MODE_16 = 4'd0;
  localparam logic [3:0] MODE_32 = 4'd1;
  localparam logic [3:0] MODE_64 = 4'd2;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_CAPTURE = 2'd1,
    W_COMMIT  = 2'd2
  } wr_state_e;

  // Frame length implied by sample_mode; unknown codes keep the previous length.
  function automatic logic [ADC_LEN_W-1:0] mode_len(input logic [3:0]           mode,
                                                    input logic [ADC_LEN_W-1:0] prev);
    case (mode)
      MODE_16: mode_len = ADC_LEN_W'(16);
      MODE_32: mode_len = ADC_LEN_W'(32);
      MODE_64: mode_len = ADC_LEN_W'(64);
      default: mode_len = prev;
    endcase
  endfunction

endpackage

// File: rtl/adc_rx_bank_ram.sv
// Ping-pong sample store: two banks of 2**ADDR_W words, address {bank, idx}.
// Synchronous write port, registered read port (read data resets to 0 so
// rd_data is clean out of reset).
module adc_rx_bank_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_frame_recv.sv
// Receive side of the ADC sample link. Captures sample bursts into a
// ping-pong buffer, checks frame length against sample_mode and hands
// whole frames to a reader while the next frame is being captured.
// Optional: define ADC_RX_TIMEOUT_EN to abort a frame after TIMEOUT_CYC
// idle cycles in W_CAPTURE.
module adc_frame_recv
  import adc_link_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int MAX_DEPTH   = ADC_MAX_DEPTH,
  parameter int ADDR_W      = ADC_ADDR_W,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              sync_in,
  input  logic [3:0]        sample_mode,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_ready,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_err,
  output logic              overflow,
  output logic              busy
);

  localparam int              LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(MAX_DEPTH);

  if (TIMEOUT_CYC < 1) begin : g_tmo_chk
    $error("adc_frame_recv: TIMEOUT_CYC must be at least 1");
  end

  // Write side
  wr_state_e        state;
  logic             wr_bank;
  logic [LEN_W-1:0] wr_cnt;
  logic [LEN_W-1:0] exp_len;
  logic             lost;      // a word hit a still-occupied bank: frame unusable
  logic             ovf_err;   // words beyond MAX_DEPTH were dropped

  // Bank bookkeeping / read side
  logic [1:0]             full, err_q;
  logic [1:0][LEN_W-1:0]  len_q;
  logic                   rd_bank;   // oldest full bank; frames alternate banks
  logic [ADDR_W-1:0]      rd_ptr;

  logic [1:0]             full_nxt, err_nxt;
  logic [1:0][LEN_W-1:0]  len_nxt;
  logic                   rd_bank_nxt;

  logic                   we;
  logic [ADDR_W-1:0]      wr_idx;
  logic                   at_max, rd_acc, rd_last, bank_free, commit_ok, err_new;
  logic                   tmo_abort;

  assign at_max    = (wr_cnt >= DEPTH_L);
  assign rd_acc    = rd_en & frame_ready;
  assign rd_last   = rd_acc & ({1'b0, rd_ptr} == (len_q[rd_bank] - 1'b1));
  // A bank emptied by the final read this cycle is free for a same-cycle commit.
  assign bank_free = ~full[wr_bank] | (rd_last & (rd_bank == wr_bank));
  assign commit_ok = (state == W_COMMIT) & bank_free & ~lost;
  assign err_new   = ovf_err | (wr_cnt != exp_len);

`ifdef ADC_RX_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_abort = (state == W_CAPTURE) & ~din_valid & ~sync_in & (tmo_cnt == TMO_LAST);

  // Idle-cycle counter while capturing; any valid word restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          tmo_cnt <= '0;
    else if (state != W_CAPTURE || din_valid) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_abort = 1'b0;
`endif

  // RAM write enable; writes into an occupied bank are suppressed to protect its frame
  always_comb begin
    we     = 1'b0;
    wr_idx = '0;
    case (state)
      W_IDLE:    if (din_valid) we = ~full[wr_bank];
      W_CAPTURE: if (din_valid && !at_max) begin
                   we     = ~full[wr_bank];
                   wr_idx = wr_cnt[ADDR_W-1:0];
                 end
      default: ;
    endcase
  end

  // Next bank state: final read frees the oldest bank, commit fills the write bank
  always_comb begin
    full_nxt    = full;
    len_nxt     = len_q;
    err_nxt     = err_q;
    rd_bank_nxt = rd_bank;
    if (rd_last) begin
      full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt       = ~rd_bank;
    end
    if (commit_ok) begin
      full_nxt[wr_bank] = 1'b1;
      len_nxt[wr_bank]  = wr_cnt;
      err_nxt[wr_bank]  = err_new;
    end
  end

  // Bank flags and the registered view of the pending frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full        <= '0;
      len_q       <= '0;
      err_q       <= '0;
      rd_bank     <= 1'b0;
      frame_ready <= 1'b0;
      frame_len   <= '0;
      frame_err   <= 1'b0;
    end else begin
      full        <= full_nxt;
      len_q       <= len_nxt;
      err_q       <= err_nxt;
      rd_bank     <= rd_bank_nxt;
      frame_ready <= full_nxt[rd_bank_nxt];
      frame_len   <= full_nxt[rd_bank_nxt] ? len_nxt[rd_bank_nxt] : '0;
      frame_err   <= full_nxt[rd_bank_nxt] & err_nxt[rd_bank_nxt];
    end
  end

  // Read pointer and data-valid flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_last)     rd_ptr <= '0;
      else if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write FSM: capture, length check, commit or drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= W_IDLE;
      wr_bank  <= 1'b0;
      wr_cnt   <= '0;
      exp_len  <= LEN_W'(16);
      lost     <= 1'b0;
      ovf_err  <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (state)
        W_IDLE: begin
          if (din_valid) begin
            wr_cnt  <= LEN_W'(1);
            exp_len <= LEN_W'(mode_len(sample_mode, ADC_LEN_W'(exp_len)));
            lost    <= full[wr_bank];
            ovf_err <= 1'b0;
            busy    <= 1'b1;
            state   <= sync_in ? W_COMMIT : W_CAPTURE;
          end
        end
        W_CAPTURE: begin
          if (din_valid) begin
            if (at_max) ovf_err <= 1'b1;
            else begin
              wr_cnt <= wr_cnt + 1'b1;
              if (full[wr_bank]) lost <= 1'b1;
            end
          end
          if (sync_in) state <= W_COMMIT;
          else if (tmo_abort) begin
            state  <= W_IDLE;
            wr_cnt <= '0;
            busy   <= 1'b0;
          end
        end
        W_COMMIT: begin
          wr_cnt <= '0;
          busy   <= 1'b0;
          state  <= W_IDLE;
          if (commit_ok) wr_bank  <= ~wr_bank;
          else           overflow <= 1'b1;
        end
        default: begin
          state <= W_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  adc_rx_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   ({wr_bank, wr_idx}),
    .wdata   (din),
    .re      (rd_acc),
    .raddr   ({rd_bank, rd_ptr}),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_adc_frame_recv.sv
// Directed bench for adc_frame_recv. Inputs change on negedge, outputs are
// sampled on negedge. The timeout scenario follows ADC_RX_TIMEOUT_EN.
module tb_adc_frame_recv;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] din;
  logic        din_valid, sync_in, rd_en;
  logic [3:0]  sample_mode;
  logic [15:0] rd_data;
  logic        rd_valid, frame_ready, frame_err, overflow, busy;
  logic [6:0]  frame_len;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_frame_recv #(.TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync_in     (sync_in),
    .sample_mode (sample_mode),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n words base..base+n-1; sync either with the last word or one cycle later.
  // Returns at the negedge one cycle after the sync cycle.
  task automatic send_frame(input int n, input logic [15:0] base, input bit sync_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din       = base + 16'(i);
      din_valid = 1'b1;
      sync_in   = sync_last && (i == n - 1);
    end
    if (!sync_last) begin
      @(negedge clk);
      din_valid = 1'b0;
      sync_in   = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    sync_in   = 1'b0;
  endtask

  // Pop n words back to back, expecting base..base+n-1.
  task automatic read_frame(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) chk("rd_data", rd_data, base + 16'(i - 1));
      rd_en = 1'b1;
    end
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_valid_last", rd_valid, 1);
    chk("rd_data_last", rd_data, base + 16'(n - 1));
  endtask

  initial begin
    reset_n = 1'b0; din = '0; din_valid = 1'b0; sync_in = 1'b0;
    sample_mode = 4'd0; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;

    // Mode 0, 16 words, sync after last word; latency sync -> ready = 2
    sample_mode = 4'd0;
    send_frame(16, 16'h0001, 1'b0);
    chk("t1_ready_early", frame_ready, 0);
    chk("t1_busy_commit", busy, 1);
    @(negedge clk);
    chk("t1_ready", frame_ready, 1);
    chk("t1_len", frame_len, 16);
    chk("t1_err", frame_err, 0);
    chk("t1_busy_idle", busy, 0);
    read_frame(16, 16'h0001);
    chk("t1_ready_after", frame_ready, 0);
    // rd_en with nothing pending is ignored
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("t1_rd_ignored", rd_valid, 0);

    // Mode 2, 64 words, sync with word 64
    sample_mode = 4'd2;
    send_frame(64, 16'h0100, 1'b1);
    @(negedge clk);
    chk("t2_ready", frame_ready, 1);
    chk("t2_len", frame_len, 64);
    chk("t2_err", frame_err, 0);
    read_frame(64, 16'h0100);

    // Mode 1 with only 20 words -> length error
    sample_mode = 4'd1;
    send_frame(20, 16'h0200, 1'b0);
    @(negedge clk);
    chk("t3a_len", frame_len, 20);
    chk("t3a_err", frame_err, 1);
    read_frame(20, 16'h0200);

    // Mode 2 with 70 words -> clipped at 64, error
    sample_mode = 4'd2;
    send_frame(70, 16'h0300, 1'b0);
    @(negedge clk);
    chk("t3b_len", frame_len, 64);
    chk("t3b_err", frame_err, 1);
    read_frame(64, 16'h0300);

    // Three frames, no reads: first two held, third dropped with overflow
    sample_mode = 4'd0;
    send_frame(16, 16'h0400, 1'b0);
    send_frame(16, 16'h0500, 1'b0);
    send_frame(16, 16'h0600, 1'b0);
    @(negedge clk);
    chk("t4_overflow", overflow, 1);
    chk("t4_ready", frame_ready, 1);
    chk("t4_len", frame_len, 16);
    @(negedge clk);
    chk("t4_overflow_pulse", overflow, 0);
    read_frame(16, 16'h0400);
    chk("t4_ready_second", frame_ready, 1);
    chk("t4_len_second", frame_len, 16);
    read_frame(16, 16'h0500);
    chk("t4_ready_empty", frame_ready, 0);

    // Reset in the middle of a capture, then a clean frame
    sample_mode = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      din = 16'h0700 + 16'(i);
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_ready", frame_ready, 0);
    chk("t5_rd_valid", rd_valid, 0);
    chk("t5_rd_data", rd_data, 0);
    chk("t5_len", frame_len, 0);
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(16, 16'h0800, 1'b0);
    @(negedge clk);
    chk("t5_ready_new", frame_ready, 1);
    chk("t5_len_new", frame_len, 16);
    chk("t5_err_new", frame_err, 0);
    read_frame(16, 16'h0800);

    // Five words then silence
    sample_mode = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din = 16'h0900 + 16'(i);
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    chk("t6_busy_capture", busy, 1);
    repeat (12) @(negedge clk);
`ifdef ADC_RX_TIMEOUT_EN
    chk("t6_busy_abort", busy, 0);
    chk("t6_ready_abort", frame_ready, 0);
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_ready_after_sync", frame_ready, 0);
    chk("t6_overflow_after_sync", overflow, 0);
`else
    chk("t6_busy_wait", busy, 1);
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    @(negedge clk);
    chk("t6_ready", frame_ready, 1);
    chk("t6_len", frame_len, 5);
    chk("t6_err", frame_err, 1);
    read_frame(5, 16'h0900);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
